median_arb: RTL and testbench

- Shares one MEDIAN core (serial 9-pixel median engine) between N_REQ pixel-window clients.
- Round-robin grants one client at a time and collects its N_PIXELS window into a local buffer; client pixel gaps are allowed.
- Bursts the window into the core with DSI contiguous, waits for the core's DSO, captures DO and returns the median to the granted client through a valid/ack handshake.

---
 rtl/median_pkg.sv | 22 ++
 rtl/median_arb_if.sv | 34 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/median_arb.sv | 210 +++++++++++++++++++++
 tb/tb_median_arb.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// median_pkg : shared state encoding, default sizes and pixel type for median_arb
// Rev 1.0
// ============================================================================
package median_pkg;

    localparam int MEDIAN_WIDTH    = 8;
    localparam int MEDIAN_N_PIXELS = 9;

    typedef logic [MEDIAN_WIDTH-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        BURST   = 3'd2,
        WAIT    = 3'd3,
        RESULT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/median_arb_if.sv
`default_nettype none
// ============================================================================
// median_arb_if : client-side and core-side buses of the median arbiter
// Rev 1.0
// ============================================================================
interface median_arb_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       REQ;
    logic [N_REQ-1:0]       GNT;
    logic [N_REQ-1:0]       PIX_VLD;
    logic [N_REQ*WIDTH-1:0] PIX;
    logic                   PIX_RDY;
    logic [WIDTH-1:0]       RES;
    logic [N_REQ-1:0]       RES_VLD;
    logic [N_REQ-1:0]       RES_ACK;
    logic                   ERR;
    logic                   M_DSI;
    logic [WIDTH-1:0]       M_DI;
    logic [WIDTH-1:0]       M_DO;
    logic                   M_DSO;

    modport slave (
        input  REQ, PIX_VLD, PIX, RES_ACK, M_DO, M_DSO,
        output GNT, PIX_RDY, RES, RES_VLD, ERR, M_DSI, M_DI
    );

    modport master (
        output REQ, PIX_VLD, PIX, RES_ACK, M_DO, M_DSO,
        input  GNT, PIX_RDY, RES, RES_VLD, ERR, M_DSI, M_DI
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching upward from ptr+1
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic [PW-1:0]    ptr_i,
    output logic      [N_REQ-1:0] gnt_o
);
    int idx;

    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_i) + i) % N_REQ;
            if (gnt_o == '0 && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/median_arb.sv
`default_nettype none
// ============================================================================
// median_arb : round-robin share of one serial median core among N_REQ clients
// Rev 1.0    : optional WAIT timeout abort enabled by MEDIAN_ARB_TIMEOUT_EN
// ============================================================================
module median_arb
    import median_pkg::*;
#(
    parameter int WIDTH    = MEDIAN_WIDTH,
    parameter int N_PIXELS = MEDIAN_N_PIXELS,
    parameter int N_REQ    = 4,
    parameter int TIMEOUT  = 64
) (
    input  wire logic   CLK,
    input  wire logic   nRST,
    median_arb_if.slave bus
);
    localparam int            CW       = $clog2(N_PIXELS);
    localparam int            PW       = $clog2(N_REQ);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_PIXELS - 1);

    generate
        if (N_PIXELS < 3 || (N_PIXELS % 2) == 0 || N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
            $error("median_arb: illegal parameter set");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             pix_rdy_q, pix_rdy_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [N_REQ-1:0] res_vld_q, res_vld_d;
    logic             dsi_q, dsi_d;
    logic [WIDTH-1:0] di_q, di_d;
    logic [WIDTH-1:0] win_q [N_PIXELS];
    logic [WIDTH-1:0] win_d [N_PIXELS];

    logic [N_REQ-1:0] w_pick;
    logic [PW-1:0]    w_pick_idx;
    logic             w_req_g;
    logic             w_vld_g;
    logic             w_ack_g;
    logic [WIDTH-1:0] w_pix_g;

`ifdef MEDIAN_ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i (bus.REQ),
        .ptr_i (ptr_q),
        .gnt_o (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = PW'(i);
        end
    end

    // Only the granted client's lines are ever looked at
    assign w_req_g = bus.REQ[ptr_q];
    assign w_vld_g = bus.PIX_VLD[ptr_q];
    assign w_ack_g = bus.RES_ACK[ptr_q];
    assign w_pix_g = bus.PIX[int'(ptr_q)*WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        pix_rdy_d = pix_rdy_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        dsi_d     = 1'b0;
        di_d      = di_q;
        win_d     = win_q;
`ifdef MEDIAN_ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    gnt_d     = w_pick;
                    ptr_d     = w_pick_idx;
                    cnt_d     = '0;
                    pix_rdy_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (!w_req_g) begin
                    gnt_d     = '0;
                    pix_rdy_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (w_vld_g) begin
                    win_d[cnt_q] = w_pix_g;
                    if (cnt_q == LAST_IDX) begin
                        // First burst beat is presented in the same cycle BURST is entered
                        cnt_d     = '0;
                        pix_rdy_d = 1'b0;
                        dsi_d     = 1'b1;
                        di_d      = win_q[0];
                        state_d   = BURST;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            BURST: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = WAIT;
`ifdef MEDIAN_ARB_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    dsi_d = 1'b1;
                    di_d  = win_q[cnt_q + CW'(1)];
                end
            end
            WAIT: begin
                if (bus.M_DSO) begin
                    res_d     = bus.M_DO;
                    res_vld_d = gnt_q;
                    state_d   = RESULT;
`ifdef MEDIAN_ARB_TIMEOUT_EN
                    err_d     = 1'b0;
                end else if (tcnt_q == TMO_LAST) begin
                    res_d     = '0;
                    res_vld_d = gnt_q;
                    err_d     = 1'b1;
                    state_d   = RESULT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
`endif
                end
            end
            RESULT: begin
                if (w_ack_g) begin
                    res_vld_d = '0;
                    gnt_d     = '0;
                    state_d   = IDLE;
`ifdef MEDIAN_ARB_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            cnt_q     <= '0;
            gnt_q     <= '0;
            pix_rdy_q <= 1'b0;
            res_q     <= '0;
            res_vld_q <= '0;
            dsi_q     <= 1'b0;
            di_q      <= '0;
            for (int i = 0; i < N_PIXELS; i++) win_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            pix_rdy_q <= pix_rdy_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            dsi_q     <= dsi_d;
            di_q      <= di_d;
            win_q     <= win_d;
        end
    end

`ifdef MEDIAN_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign bus.ERR = err_q;
`else
    assign bus.ERR = 1'b0;
`endif

    assign bus.GNT     = gnt_q;
    assign bus.PIX_RDY = pix_rdy_q;
    assign bus.RES     = res_q;
    assign bus.RES_VLD = res_vld_q;
    assign bus.M_DSI   = dsi_q;
    assign bus.M_DI    = di_q;
endmodule
`default_nettype wire

// File: tb/tb_median_arb.sv
`default_nettype none
// ============================================================================
// tb_median_arb : randomized scoreboard bench for median_arb with a core model
// Rev 1.0       : timeout scenarios run when MEDIAN_ARB_TIMEOUT_EN is defined
// ============================================================================
module tb_median_arb;
    import median_pkg::*;

    localparam int W   = 8;
    localparam int NP  = 9;
    localparam int NR  = 4;
    localparam int TMO = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    median_arb_if #(.WIDTH(W), .N_REQ(NR)) bus ();

    median_arb #(.WIDTH(W), .N_PIXELS(NP), .N_REQ(NR), .TIMEOUT(TMO)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    typedef struct {int k; int res; bit err;} exp_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    pixel_t exp_burst[$];
    int     grant_log[$];
    int     exp_grants[$];
    int     core_mode  = 0;
    int     model_last = NR - 1;
    int     rem[NR];
    int     fixed_px[NP] = '{9, 3, 7, 1, 5, 8, 2, 6, 4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int median_of(input pixel_t a[NP]);
        pixel_t s[NP];
        pixel_t t;
        s = a;
        for (int i = 1; i < NP; i++)
            for (int j = i; j > 0; j--)
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
        return int'(s[NP/2]);
    endfunction

    // Reference round-robin: each client with jobs left keeps requesting
    task automatic expect_rr();
        bit any;
        exp_grants.delete();
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int d = 1; d <= NR; d++) begin
                int c;
                c = (model_last + d) % NR;
                if (rem[c] > 0) begin
                    exp_grants.push_back(c);
                    rem[c]--;
                    model_last = c;
                    any = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, grant_log.size(), exp_grants.size());
        for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++)
            check({name, "_order"}, grant_log[i], exp_grants[i]);
    endtask

    task automatic run_client(input int k, input int njobs, input bit gaps,
                              input int abort_after, input bit fixed, input bit tmo);
        pixel_t px[NP];
        exp_t   e;
        int     idx, g, wc;
        bit     quit;
        quit = 1'b0;
        for (int j = 0; j < njobs && !quit; j++) begin
            for (int i = 0; i < NP; i++)
                px[i] = fixed ? pixel_t'(fixed_px[i]) : pixel_t'($urandom_range(0, 255));
            bus.REQ[k] = 1'b1;
            idx = 0; g = 0; wc = 0;
            while (idx < NP && !quit) begin
                @(negedge clk);
                bus.PIX_VLD[k] = 1'b0;
                wc = wc + 1;
                if (!nrst) quit = 1'b1;
                else if (wc > 1000) begin
                    check("collect_timeout", wc, 0);
                    quit = 1'b1;
                end else if (bus.GNT[k] && bus.PIX_RDY) begin
                    if (abort_after >= 0 && idx == abort_after) quit = 1'b1;
                    else begin
                        if (!gaps || (g % 3) == 0) begin
                            bus.PIX_VLD[k]       = 1'b1;
                            bus.PIX[k*W +: W]    = px[idx];
                            if (abort_after < 0) exp_burst.push_back(px[idx]);
                            idx++;
                        end
                        g++;
                    end
                end
            end
            if (!quit) begin
                e.k = k; e.res = tmo ? 0 : median_of(px); e.err = tmo;
                exp_q.push_back(e);
                wc = 0;
                while (!quit && !bus.RES_VLD[k]) begin
                    @(negedge clk);
                    bus.PIX_VLD[k] = 1'b0;
                    wc = wc + 1;
                    if (!nrst) quit = 1'b1;
                    else if (wc > 1000) begin
                        check("result_timeout", wc, 0);
                        quit = 1'b1;
                    end
                end
                if (!quit) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    if (!nrst) quit = 1'b1;
                    else begin
                        check("res_hold_vld", bus.RES_VLD, 64'(1) << k);
                        check("res_hold_val", bus.RES, e.res);
                        bus.RES_ACK[k] = 1'b1;
                        if (j == njobs - 1) bus.REQ[k] = 1'b0;
                        @(negedge clk);
                        bus.RES_ACK[k] = 1'b0;
                    end
                end
            end
        end
        bus.REQ[k]     = 1'b0;
        bus.PIX_VLD[k] = 1'b0;
        bus.RES_ACK[k] = 1'b0;
    endtask

    // Grant log, one-hot/gap checks and PIX_RDY phase check
    logic [NR-1:0] g_prev = '0;
    bit            collecting = 1'b0;
    always @(negedge clk) begin
        if (!nrst) begin
            collecting = 1'b0;
            g_prev     = '0;
        end else begin
            if (bus.GNT != g_prev && bus.GNT != '0) begin
                check("gnt_onehot", $onehot(bus.GNT), 1);
                check("gnt_gap", g_prev, 0);
                for (int i = 0; i < NR; i++) if (bus.GNT[i]) grant_log.push_back(i);
                collecting = 1'b1;
            end
            if (bus.M_DSI || bus.GNT == '0) collecting = 1'b0;
            check("pix_rdy", bus.PIX_RDY, collecting);
            g_prev = bus.GNT;
        end
    end

    // Burst order and contiguity
    int burst_run = 0;
    always @(negedge clk) begin
        if (!nrst) burst_run = 0;
        else if (bus.M_DSI) begin
            burst_run++;
            if (exp_burst.size() == 0) check("burst_unexpected", bus.M_DI, 0);
            else check("burst_data", bus.M_DI, exp_burst.pop_front());
        end else if (burst_run > 0) begin
            check("burst_len", burst_run, NP);
            burst_run = 0;
        end
    end

    // Result scoreboard
    logic [NR-1:0] v_prev = '0;
    int            since_dsi = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            v_prev    = '0;
            since_dsi = 0;
        end else begin
            if (bus.M_DSI) since_dsi = 0;
            else since_dsi++;
            if (bus.RES_VLD != '0 && v_prev == '0) begin
                if (exp_q.size() == 0) check("res_unexpected", bus.RES_VLD, 0);
                else begin
                    e = exp_q.pop_front();
                    check("res_value", bus.RES, e.res);
                    check("res_vld", bus.RES_VLD, 64'(1) << e.k);
                    check("res_err", bus.ERR, e.err);
                    if (core_mode == 1) check("tmo_latency", since_dsi, TMO + 1);
                end
            end
            v_prev = bus.RES_VLD;
        end
    end

    // Median core model: answers after a delay counted from the end of a burst
    pixel_t core_buf[NP];
    int     core_n = 0, core_cnt = 0, core_delay = 0, core_med = 0;
    bit     core_pend = 1'b0;
    always @(negedge clk) begin
        if (!nrst) begin
            core_n = 0; core_pend = 1'b0;
            bus.M_DSO = 1'b0; bus.M_DO = '0;
        end else begin
            bus.M_DSO = 1'b0;
            if (bus.M_DSI) begin
                if (core_n < NP) core_buf[core_n] = bus.M_DI;
                core_n++;
                core_pend = 1'b0;
            end else if (core_n > 0) begin
                core_med   = median_of(core_buf);
                core_n     = 0;
                core_cnt   = 0;
                core_pend  = (core_mode != 1);
                core_delay = (core_mode == 2) ? TMO : $urandom_range(1, 6);
            end
            if (core_pend) begin
                core_cnt++;
                if (core_cnt == core_delay) begin
                    bus.M_DSO = 1'b1;
                    bus.M_DO  = pixel_t'(core_med);
                    core_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        bus.REQ = '0; bus.PIX_VLD = '0; bus.PIX = '0; bus.RES_ACK = '0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.GNT, 0);
        check("rst_pix_rdy", bus.PIX_RDY, 0);
        check("rst_res", bus.RES, 0);
        check("rst_res_vld", bus.RES_VLD, 0);
        check("rst_err", bus.ERR, 0);
        check("rst_dsi", bus.M_DSI, 0);
        check("rst_di", bus.M_DI, 0);
        nrst = 1'b1;

        // Single client, fixed window, median 5
        grant_log.delete();
        run_client(0, 1, 1'b0, -1, 1'b1, 1'b0);
        rem = '{1, 0, 0, 0}; expect_rr(); check_grants("t_single");

        // Three continuous requesters
        grant_log.delete();
        fork
            run_client(0, 2, 1'b0, -1, 1'b0, 1'b0);
            run_client(2, 2, 1'b0, -1, 1'b0, 1'b0);
            run_client(3, 2, 1'b0, -1, 1'b0, 1'b0);
        join
        rem = '{2, 0, 2, 2}; expect_rr(); check_grants("t_rr");

        // Pixel gaps
        grant_log.delete();
        run_client(1, 1, 1'b1, -1, 1'b0, 1'b0);
        rem = '{0, 1, 0, 0}; expect_rr(); check_grants("t_gaps");

        // Abort after 4 pixels, client 1 pending
        grant_log.delete();
        fork
            run_client(0, 1, 1'b0, 4, 1'b0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                run_client(1, 1, 1'b1, -1, 1'b0, 1'b0);
            end
        join
        exp_grants.delete(); exp_grants.push_back(0); exp_grants.push_back(1);
        model_last = 1;
        check_grants("t_abort");

        // Reset during burst
        fork
            run_client(2, 1, 1'b0, -1, 1'b0, 1'b0);
            begin
                wc = 0;
                while (!bus.M_DSI && wc < 500) begin @(negedge clk); wc++; end
                check("rst_burst_seen", bus.M_DSI, 1);
                @(posedge clk);
                #2 nrst = 1'b0;
                #1;
                check("rst_dsi_async", bus.M_DSI, 0);
                check("rst_gnt_async", bus.GNT, 0);
                repeat (2) @(negedge clk);
                nrst = 1'b1;
            end
        join
        @(negedge clk);
        check("post_rst_gnt", bus.GNT, 0);
        check("post_rst_pix_rdy", bus.PIX_RDY, 0);
        check("post_rst_res_vld", bus.RES_VLD, 0);
        exp_burst.delete(); exp_q.delete();
        model_last = NR - 1;
        grant_log.delete();
        run_client(3, 1, 1'b0, -1, 1'b0, 1'b0);
        rem = '{0, 0, 0, 1}; expect_rr(); check_grants("t_post_rst");

`ifdef MEDIAN_ARB_TIMEOUT_EN
        core_mode = 1;
        run_client(1, 1, 1'b0, -1, 1'b0, 1'b1);
        core_mode = 2;
        run_client(1, 1, 1'b0, -1, 1'b0, 1'b0);
        core_mode = 0;
`endif

        repeat (4) @(negedge clk);
        check("drain_results", exp_q.size(), 0);
        check("drain_burst", exp_burst.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
